// File: rtl/serial_addsub.sv
// serial_addsub
//   Bit-serial add/subtract unit for the multicycle ALU path. A single
//   full-adder cell is iterated LSB-first over WIDTH cycles. For subtraction
//   the B bit is inverted and the carry is seeded with 1, so the unit
//   computes A + ~B + 1 = A - B.
//
//   Optional feature: define ADDSUB_SLT_EN to add the slt output. slt is the
//   signed A<B flag for subtraction and 0 for addition, updated with done.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   start   in   operation request; operands captured when accepted
//   sub     in   0 = A+B, 1 = A-B; captured with start
//   a, b    in   WIDTH-bit operands
//   busy    out  high while the operation is running
//   done    out  one-cycle pulse when result/co/ovf/zero are valid
//   result  out  sum/difference; held until the next accepted start
//   co      out  carry out of the MSB (for sub: 1 = no borrow)
//   ovf     out  signed overflow
//   zero    out  result == 0
//   slt     out  signed A<B (only with ADDSUB_SLT_EN)

module serial_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ovf,
`ifdef ADDSUB_SLT_EN
    output logic             zero,
    output logic             slt
`else
    output logic             zero
`endif
);

    // state | meaning
    // IDLE  | waiting for start; previous result held
    // RUN   | one bit processed per clock, LSB first
    // DONE  | result valid for exactly one cycle; start accepted here too
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    count;
    logic             sub_q;
    logic             carry;
    logic             c_msb;     // carry into the MSB, kept for the overflow term

    logic             accept;
    logic             bit_a;
    logic             bit_b;
    logic             sum_bit;
    logic             c_next;
    logic [WIDTH-1:0] shifted;

    assign accept = start && (state_q != RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (count == LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    // Shared full-adder cell
    assign bit_a   = a_sh[0];
    assign bit_b   = b_sh[0] ^ sub_q;
    assign sum_bit = bit_a ^ bit_b ^ carry;
    assign c_next  = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 is at the LSB
    assign shifted = {sum_bit, result[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            count  <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            c_msb  <= 1'b0;
            result <= '0;
            co     <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
`ifdef ADDSUB_SLT_EN
            slt    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sub_q  <= sub;
            carry  <= sub;
            count  <= '0;
            c_msb  <= 1'b0;
            result <= '0;
        end else if (state_q == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            result <= shifted;
            carry  <= c_next;
            count  <= count + 1'b1;
            if (count == PENULT) begin
                c_msb <= c_next;
            end
            if (count == LAST) begin
                co   <= c_next;
                ovf  <= c_msb ^ c_next;
                zero <= (shifted == '0);
`ifdef ADDSUB_SLT_EN
                // sign of the difference corrected by overflow gives signed A<B
                slt  <= sub_q & (sum_bit ^ c_msb ^ c_next);
`endif
            end
        end
    end

endmodule
